ccl_first_pass: RTL and testbench

First-pass connected-component labeler for the binary-mask video path; sits directly upstream of union_find. Scans a binary pixel stream in raster order, assigns provisional labels using 4-connectivity (left, up), and issues union requests to union_find whenever two different labels meet. Emits the provisional label stream for the downstream label-resolution pass. Stalls the pixel stream while a union is outstanding.

---
 rtl/ccl_pkg.sv | 26 ++
 rtl/ccl_line_buf.sv | 37 +++
 rtl/ccl_first_pass.sv | 227 ++++++++++++++++++++++
 tb/tb_ccl_first_pass.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccl_pkg.sv
//------------------------------------------------------------------------------
// Module  : ccl_pkg
// Brief   : Shared constants for the first-pass connected-component labeler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ccl_pkg;

    localparam logic [1:0] UF_OP_FIND  = 2'b00;
    localparam logic [1:0] UF_OP_UNION = 2'b01;

    localparam int LABEL_BG = 0;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_UNION_REQ  = 2'd1;
    localparam logic [1:0] ST_UNION_WAIT = 2'd2;

    // Address width for a table of v entries, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ccl_line_buf.sv
//------------------------------------------------------------------------------
// Module  : ccl_line_buf
// Brief   : One-line label buffer; 1-cycle registered read, independent write.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ccl_line_buf
    import ccl_pkg::*;
#(
    parameter int DEPTH = 1280,
    parameter int WIDTH = 8,
    parameter int AW    = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[rd_addr];
    end

    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/ccl_first_pass.sv
//------------------------------------------------------------------------------
// Module  : ccl_first_pass
// Brief   : Raster-scan provisional labeler (4-connectivity) issuing unions.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ccl_first_pass
    import ccl_pkg::*;
#(
    parameter int IMG_W      = 1280,
    parameter int IMG_H      = 720,
    parameter int ADDR_WIDTH = 8,
    parameter int N          = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic                  pix_bin,
    output logic                  pix_ready,
    output logic                  label_valid,
    output logic [ADDR_WIDTH-1:0] label_out,
    output logic                  uf_start,
    output logic [1:0]            uf_op,
    output logic [ADDR_WIDTH-1:0] uf_node1,
    output logic [ADDR_WIDTH-1:0] uf_node2,
    input  logic                  uf_done,
    output logic                  label_overflow
);

    localparam int c_col_w = clog2_min1(IMG_W);
    localparam int c_row_w = clog2_min1(IMG_H);
    localparam logic [ADDR_WIDTH-1:0] c_bg        = ADDR_WIDTH'(LABEL_BG);
    localparam logic [ADDR_WIDTH-1:0] c_max_label = ADDR_WIDTH'(N - 1);
    localparam logic [c_col_w-1:0]    c_col_last  = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0]    c_row_last  = c_row_w'(IMG_H - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  w_uf_start;

    logic [c_col_w-1:0]    r_col;
    logic [c_row_w-1:0]    r_row;
    logic [ADDR_WIDTH-1:0] r_next_label;
    logic                  r_sat;
    logic                  r_overflow;
    logic                  r_fs_pending;
    logic [ADDR_WIDTH-1:0] r_left;
    logic                  r_pix_ready;
    logic                  r_label_valid;
    logic [ADDR_WIDTH-1:0] r_label_out;
    logic [ADDR_WIDTH-1:0] r_uf_node1;
    logic [ADDR_WIDTH-1:0] r_uf_node2;

    logic                  w_accept;
    logic                  w_fs_apply;
    logic [c_col_w-1:0]    w_col_cur;
    logic [c_row_w-1:0]    w_row_cur;
    logic [ADDR_WIDTH-1:0] w_next_label_cur;
    logic                  w_sat_cur;
    logic                  w_ovf_cur;
    logic [ADDR_WIDTH-1:0] w_rd_data;
    logic [ADDR_WIDTH-1:0] w_left;
    logic [ADDR_WIDTH-1:0] w_up;
    logic [ADDR_WIDTH-1:0] w_lo;
    logic [ADDR_WIDTH-1:0] w_hi;
    logic [ADDR_WIDTH-1:0] w_label;
    logic                  w_new;
    logic                  w_merge;
    logic [c_col_w-1:0]    w_col_nxt;
    logic [c_row_w-1:0]    w_row_nxt;
    logic [ADDR_WIDTH-1:0] w_next_label_nxt;
    logic                  w_sat_nxt;
    logic                  w_ovf_nxt;

    assign w_accept = pix_valid && r_pix_ready;

    // Frame restart takes effect in the same cycle so a coincident pixel lands at (0,0).
    always_comb begin
        w_fs_apply       = (r_state == ST_RUN) && (frame_start || r_fs_pending);
        w_col_cur        = w_fs_apply ? '0 : r_col;
        w_row_cur        = w_fs_apply ? '0 : r_row;
        w_next_label_cur = w_fs_apply ? ADDR_WIDTH'(1) : r_next_label;
        w_sat_cur        = w_fs_apply ? 1'b0 : r_sat;
        w_ovf_cur        = w_fs_apply ? 1'b0 : r_overflow;

        w_left = (w_col_cur == '0) ? c_bg : r_left;
        w_up   = (w_row_cur == '0) ? c_bg : w_rd_data;
        w_lo   = (w_left < w_up) ? w_left : w_up;
        w_hi   = (w_left < w_up) ? w_up : w_left;

        w_label = c_bg;
        w_new   = 1'b0;
        w_merge = 1'b0;
        if (pix_bin) begin
            if (w_left == c_bg && w_up == c_bg) begin
                w_new   = 1'b1;
                w_label = w_sat_cur ? c_max_label : w_next_label_cur;
            end else if (w_left == c_bg) begin
                w_label = w_up;
            end else if (w_up == c_bg || w_up == w_left) begin
                w_label = w_left;
            end else begin
                w_label = w_lo;
                w_merge = 1'b1;
            end
        end

        // Once the top label has been handed out, further new components reuse it.
        w_next_label_nxt = w_next_label_cur;
        w_sat_nxt        = w_sat_cur;
        w_ovf_nxt        = w_ovf_cur;
        if (w_accept && w_new) begin
            if (w_sat_cur) begin
                w_ovf_nxt = 1'b1;
            end else if (w_next_label_cur == c_max_label) begin
                w_sat_nxt = 1'b1;
            end else begin
                w_next_label_nxt = w_next_label_cur + 1'b1;
            end
        end

        w_col_nxt = w_col_cur;
        w_row_nxt = w_row_cur;
        if (w_accept) begin
            if (w_col_cur == c_col_last) begin
                w_col_nxt = '0;
                w_row_nxt = (w_row_cur == c_row_last) ? '0 : w_row_cur + 1'b1;
            end else begin
                w_col_nxt = w_col_cur + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_uf_start   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_accept && w_merge) begin
                    w_state_next = ST_UNION_REQ;
                end
            end
            ST_UNION_REQ: begin
                w_uf_start   = 1'b1;
                w_state_next = ST_UNION_WAIT;
            end
            ST_UNION_WAIT: begin
                if (uf_done) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col         <= '0;
            r_row         <= '0;
            r_next_label  <= ADDR_WIDTH'(1);
            r_sat         <= 1'b0;
            r_overflow    <= 1'b0;
            r_fs_pending  <= 1'b0;
            r_left        <= c_bg;
            r_pix_ready   <= 1'b0;
            r_label_valid <= 1'b0;
            r_label_out   <= c_bg;
            r_uf_node1    <= '0;
            r_uf_node2    <= '0;
        end else begin
            r_col         <= w_col_nxt;
            r_row         <= w_row_nxt;
            r_next_label  <= w_next_label_nxt;
            r_sat         <= w_sat_nxt;
            r_overflow    <= w_ovf_nxt;
            r_fs_pending  <= (r_state != ST_RUN) && (r_fs_pending || frame_start);
            r_pix_ready   <= (w_state_next == ST_RUN);
            r_label_valid <= w_accept;
            if (w_accept) begin
                r_label_out <= w_label;
                r_left      <= w_label;
            end
            if (w_accept && w_merge) begin
                r_uf_node1 <= w_lo;
                r_uf_node2 <= w_hi;
            end
        end
    end

    // Read address tracks the column of the next pixel so its up-neighbour is ready on arrival.
    ccl_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (ADDR_WIDTH),
        .AW    (c_col_w)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (w_accept),
        .wr_addr (w_col_cur),
        .wr_data (w_label),
        .rd_addr (w_col_nxt),
        .rd_data (w_rd_data)
    );

    assign pix_ready      = r_pix_ready;
    assign label_valid    = r_label_valid;
    assign label_out      = r_label_out;
    assign uf_start       = w_uf_start;
    assign uf_op          = UF_OP_UNION;
    assign uf_node1       = r_uf_node1;
    assign uf_node2       = r_uf_node2;
    assign label_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ccl_first_pass.sv
//------------------------------------------------------------------------------
// Module  : tb_ccl_first_pass
// Brief   : Scoreboard bench for ccl_first_pass with a union_find responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ccl_first_pass;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          pix_valid;
    logic          pix_bin;
    logic          pix_ready;
    logic          label_valid;
    logic [AW-1:0] label_out;
    logic          uf_start;
    logic [1:0]    uf_op;
    logic [AW-1:0] uf_node1;
    logic [AW-1:0] uf_node2;
    logic          uf_done = 1'b0;
    logic          label_overflow;

    ccl_first_pass #(
        .IMG_W      (W),
        .IMG_H      (H),
        .ADDR_WIDTH (AW),
        .N          (2**AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .pix_valid      (pix_valid),
        .pix_bin        (pix_bin),
        .pix_ready      (pix_ready),
        .label_valid    (label_valid),
        .label_out      (label_out),
        .uf_start       (uf_start),
        .uf_op          (uf_op),
        .uf_node1       (uf_node1),
        .uf_node2       (uf_node2),
        .uf_done        (uf_done),
        .label_overflow (label_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lbl;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   uni_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   uf_cnt  = 0;
    bit   prev_done  = 1'b0;
    bit   prev_start = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops plus a union_find model answering 3 cycles after uf_start.
    always @(negedge clk) begin
        exp_t e;
        int   u;
        if (reset) begin
            uf_cnt     = 0;
            uf_done    = 1'b0;
            prev_done  = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (label_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL label_unexpected: got label %0d, expected no output", label_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("label", int'(label_out), e.lbl);
                    chk("overflow", int'(label_overflow), e.ovf);
                end
            end
            if (uf_start) begin
                chk("uf_start_one_cycle", int'(prev_start), 0);
                if (uni_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL uf_unexpected: got uf_start with nodes %0d/%0d, expected none", uf_node1, uf_node2);
                end else begin
                    u = uni_q.pop_front();
                    chk("uf_node1", int'(uf_node1), u / 256);
                    chk("uf_node2", int'(uf_node2), u % 256);
                    chk("uf_op", int'(uf_op), 1);
                end
            end
            if (uf_cnt > 0 || uf_start) begin
                chk("ready_stall", int'(pix_ready), 0);
            end else if (prev_done) begin
                chk("ready_resume", int'(pix_ready), 1);
            end
            prev_start = uf_start;
            prev_done  = uf_done;
            uf_done    = 1'b0;
            if (uf_cnt > 0) begin
                uf_cnt--;
                if (uf_cnt == 0) begin
                    uf_done = 1'b1;
                end
            end
            if (uf_start) begin
                uf_cnt = 3;
            end
        end
    end

    task automatic send(input bit b, input int lbl, input int ovf, input int u1, input int u2);
        int   g = 0;
        exp_t e;
        while (!pix_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (!pix_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: pix_ready stuck at 0, expected 1");
        end
        pix_valid = 1'b1;
        pix_bin   = b;
        e.lbl = lbl;
        e.ovf = ovf;
        exp_q.push_back(e);
        if (u1 != 0) begin
            uni_q.push_back(u1 * 256 + u2);
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Checkerboard frame: pixels row-major with expected labels and overflow flags.
    bit pat_b   [16] = '{1,0,1,0, 0,1,0,1, 1,0,1,0, 0,1,0,1};
    int pat_lbl [16] = '{1,0,2,0, 0,3,0,4, 5,0,6,0, 0,7,0,7};
    int pat_ovf [16] = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1};

    initial begin
        int g;
        reset       = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_bin     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_label_valid", int'(label_valid), 0);
        chk("rst_label_out", int'(label_out), 0);
        chk("rst_uf_start", int'(uf_start), 0);
        chk("rst_uf_op", int'(uf_op), 1);
        chk("rst_uf_node1", int'(uf_node1), 0);
        chk("rst_uf_node2", int'(uf_node2), 0);
        chk("rst_overflow", int'(label_overflow), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(pix_ready), 1);

        pulse_fs();
        send(1, 1, 0, 0, 0);
        send(1, 1, 0, 0, 0);
        send(0, 0, 0, 0, 0);
        send(1, 2, 0, 0, 0);

        pulse_fs();
        send(1, 1, 0, 0, 0);
        send(0, 0, 0, 0, 0);
        send(1, 2, 0, 0, 0);
        send(0, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0);
        send(1, 1, 0, 0, 0);
        send(1, 1, 0, 1, 2);
        send(0, 0, 0, 0, 0);

        pulse_fs();
        for (int i = 0; i < 16; i++) begin
            send(pat_b[i], pat_lbl[i], pat_ovf[i], 0, 0);
        end
        send(0, 0, 1, 0, 0);
        send(0, 0, 1, 0, 0);
        pulse_fs();
        send(1, 1, 0, 0, 0);
        send(1, 1, 0, 0, 0);
        repeat (5) @(negedge clk);

        // Reset while union_find is busy.
        pulse_fs();
        send(1, 1, 0, 0, 0);
        send(0, 0, 0, 0, 0);
        send(1, 2, 0, 0, 0);
        send(0, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0);
        send(1, 1, 0, 0, 0);
        send(1, 1, 0, 1, 2);
        g = 0;
        while (uni_q.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("union_issued", uni_q.size(), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midunion_uf_start", int'(uf_start), 0);
        chk("midunion_label_valid", int'(label_valid), 0);
        chk("midunion_pix_ready", int'(pix_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midunion_ready_after", int'(pix_ready), 1);
        pulse_fs();
        send(1, 1, 0, 0, 0);
        send(0, 0, 0, 0, 0);
        send(1, 2, 0, 0, 0);

        repeat (8) @(negedge clk);
        chk("label_queue_drained", exp_q.size(), 0);
        chk("union_queue_drained", uni_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
